// File: rtl/cpu24_pkg.sv
// cpu24_pkg: shared widths, responder FSM states and byte-merge helper for the 24-bit CPU data bus
package cpu24_pkg;

    localparam int WORD_W = 24;
    localparam int ADDR_W = 24;
    localparam int BE_W   = 3;

    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} resp_state_t;

    // Replace only the bytes whose enable bit is set
    function automatic logic [WORD_W-1:0] be_merge(
        input logic [WORD_W-1:0] old_w,
        input logic [WORD_W-1:0] new_w,
        input logic [BE_W-1:0]   be
    );
        logic [WORD_W-1:0] res;
        res = old_w;
        for (int i = 0; i < BE_W; i++)
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        return res;
    endfunction

endpackage

// File: rtl/mem_array_24.sv
// mem_array_24: unreset word storage with a byte-enabled synchronous write port and a registered read port
module mem_array_24
    import cpu24_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [BE_W-1:0]   i_be,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rdata;

    // Read sees pre-write contents; storage is deliberately never reset
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_addr] <= be_merge(r_mem[i_addr], i_wdata, i_be);
        if (i_re) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: slow-memory responder answering each CPU data request with a Ready pulse after WAIT_STATES cycles
module data_memory_responder
    import cpu24_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req,
    input  logic              Wr,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [WORD_W-1:0] WData,
    input  logic [BE_W-1:0]   ByteEn,
    output logic [WORD_W-1:0] RData,
    output logic              Ready,
    output logic              Err,
    output logic              Busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    resp_state_t       r_state;
    logic [3:0]        r_cnt;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;
    logic              r_ready;
    logic              r_err;
    logic              r_busy;

    logic              w_idle;
    logic              w_wr;
    logic [ADDR_W-1:0] w_addr;
    logic [WORD_W-1:0] w_wdata;
    logic [BE_W-1:0]   w_be;
    logic              w_in_range;
    logic              w_go;
    logic [WORD_W-1:0] w_mem_rdata;

    // With zero wait states the access happens on the capture edge, so live inputs feed the array in IDLE
    assign w_idle     = (r_state == IDLE);
    assign w_wr       = w_idle ? Wr     : r_wr;
    assign w_addr     = w_idle ? Addr   : r_addr;
    assign w_wdata    = w_idle ? WData  : r_wdata;
    assign w_be       = w_idle ? ByteEn : r_be;
    assign w_in_range = {8'd0, w_addr} < 32'(DEPTH);
    assign w_go       = w_idle ? (Req && WAIT_STATES == 0) : (r_state == WAIT && r_cnt == 4'd1);

    mem_array_24 #(.DEPTH(DEPTH)) u_mem (
        .i_clk   (Clock),
        .i_we    (w_go && w_wr && w_in_range),
        .i_re    (w_go && !w_wr && w_in_range),
        .i_addr  (w_addr[IDX_W-1:0]),
        .i_wdata (w_wdata),
        .i_be    (w_be),
        .o_rdata (w_mem_rdata)
    );

    // Request FSM: capture in IDLE, count down in WAIT, one-cycle Ready in RESPOND
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ready <= w_go;
            r_err   <= w_go && !w_in_range;
            case (r_state)
                IDLE: if (Req) begin
                    r_wr    <= Wr;
                    r_addr  <= Addr;
                    r_wdata <= WData;
                    r_be    <= ByteEn;
                    r_cnt   <= 4'(WAIT_STATES);
                    r_busy  <= 1'b1;
                    r_state <= (WAIT_STATES == 0) ? RESPOND : WAIT;
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_state <= RESPOND;
                end
                RESPOND: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Out-of-range reads and non-Ready cycles present zero
    assign RData = (r_ready && !r_err) ? w_mem_rdata : '0;
    assign Ready = r_ready;
    assign Err   = r_err;
    assign Busy  = r_busy;

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: table, hand-written and random checks of the responder against a word-array model
module tb_data_memory_responder;

    localparam int DEPTH = 256;
    localparam int WS    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0, wr = 1'b0;
    logic [23:0] addr = '0, wdata = '0;
    logic [2:0]  be = '0;
    logic [23:0] rdata;
    logic        ready, err, busy;

    logic        req0 = 1'b0, wr0 = 1'b0;
    logic [23:0] addr0 = '0, wdata0 = '0;
    logic [2:0]  be0 = '0;
    logic [23:0] rdata0;
    logic        ready0, err0, busy0;

    int pass_cnt = 0;
    int total    = 0;

    logic [23:0] ref_mem [DEPTH];

    typedef struct {
        logic        wr;
        logic [23:0] a;
        logic [23:0] d;
        logic [2:0]  be;
        logic [23:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [17];

    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .Clock(clk), .Reset(rst), .Req(req), .Wr(wr), .Addr(addr), .WData(wdata),
        .ByteEn(be), .RData(rdata), .Ready(ready), .Err(err), .Busy(busy)
    );

    data_memory_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .Clock(clk), .Reset(rst), .Req(req0), .Wr(wr0), .Addr(addr0), .WData(wdata0),
        .ByteEn(be0), .RData(rdata0), .Ready(ready0), .Err(err0), .Busy(busy0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One request on the WS=2 instance; optionally scrambles all inputs while the request is in flight
    task automatic xact(input logic w, input logic [23:0] a, input logic [23:0] d, input logic [2:0] b,
                        input logic toggle, output logic [23:0] rd, output logic er);
        int lat;
        logic got;
        @(negedge clk);
        req = 1'b1; wr = w; addr = a; wdata = d; be = b;
        @(posedge clk);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (ready) got = 1'b1;
            else begin
                check("busy_wait", {31'd0, busy}, 32'd1);
                if (toggle) begin
                    req = 1'($urandom); wr = 1'($urandom); addr = 24'($urandom);
                    wdata = 24'($urandom); be = 3'($urandom);
                end
            end
        end
        rd = rdata;
        er = err;
        check("latency", lat, WS + 1);
        check("busy_ready", {31'd0, busy}, 32'd1);
        req = 1'b0;
        @(negedge clk);
        check("ready_pulse", {29'd0, ready, busy, err}, 32'd0);
    endtask

    task automatic model_write(input logic [23:0] a, input logic [23:0] d, input logic [2:0] b);
        if (a < DEPTH)
            for (int i = 0; i < 3; i++)
                if (b[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
    endtask

    // Request checked against the model's prediction, then the model absorbs it
    task automatic run_model(input string nm, input logic w, input logic [23:0] a, input logic [23:0] d,
                             input logic [2:0] b, input logic toggle);
        logic [23:0] rd, exp_rd;
        logic er;
        exp_rd = (a < DEPTH) ? ref_mem[a] : 24'd0;
        xact(w, a, d, b, toggle, rd, er);
        check({nm, "_err"}, {31'd0, er}, {31'd0, a >= DEPTH});
        if (!w) check({nm, "_rdata"}, {8'd0, rd}, {8'd0, exp_rd});
        if (w) model_write(a, d, b);
    endtask

    initial begin
        logic [23:0] rd, old9;
        logic er;
        logic [23:0] d0 [4];

        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [23:0] rd, old9;
        logic er;
        logic [23:0] d0 [4];

        tbl[0]  = '{1'b1, 24'd5,       24'hABCDEF, 3'b111, 24'h0,      1'b0};
        tbl[1]  = '{1'b0, 24'd5,       24'h0,      3'b000, 24'hABCDEF, 1'b0};
        tbl[2]  = '{1'b1, 24'd7,       24'h123456, 3'b111, 24'h0,      1'b0};
        tbl[3]  = '{1'b1, 24'd7,       24'hFFFFFF, 3'b010, 24'h0,      1'b0};
        tbl[4]  = '{1'b0, 24'd7,       24'h0,      3'b111, 24'h12FF56, 1'b0};
        tbl[5]  = '{1'b1, 24'd0,       24'h0A0B0C, 3'b111, 24'h0,      1'b0};
        tbl[6]  = '{1'b1, 24'd256,     24'h111111, 3'b111, 24'h0,      1'b1};
        tbl[7]  = '{1'b0, 24'd256,     24'h0,      3'b111, 24'h0,      1'b1};
        tbl[8]  = '{1'b0, 24'd0,       24'h0,      3'b000, 24'h0A0B0C, 1'b0};
        tbl[9]  = '{1'b1, 24'd5,       24'h000000, 3'b000, 24'h0,      1'b0};
        tbl[10] = '{1'b0, 24'd5,       24'h0,      3'b000, 24'hABCDEF, 1'b0};
        tbl[11] = '{1'b1, 24'h010007,  24'h555555, 3'b111, 24'h0,      1'b1};
        tbl[12] = '{1'b0, 24'd7,       24'h0,      3'b000, 24'h12FF56, 1'b0};
        tbl[13] = '{1'b0, 24'hFFFFFF,  24'h0,      3'b000, 24'h0,      1'b1};
        tbl[14] = '{1'b1, 24'd255,     24'hC0FFEE, 3'b111, 24'h0,      1'b0};
        tbl[15] = '{1'b1, 24'd255,     24'h000000, 3'b101, 24'h0,      1'b0};
        tbl[16] = '{1'b0, 24'd255,     24'h0,      3'b000, 24'h00FF00, 1'b0};

        rst = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_err",   {31'd0, err},   32'd0);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_rdata", {8'd0, rdata},  32'd0);
        check("rst_ws0",   {8'd0, rdata0, ready0, err0, busy0, 5'd0}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) run_model("init", 1'b1, 24'(i), 24'($urandom), 3'b111, 1'b0);

        for (int i = 0; i < 17; i++) begin
            xact(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].be, 1'b0, rd, er);
            check($sformatf("tbl%0d_err", i), {31'd0, er}, {31'd0, tbl[i].exp_err});
            if (!tbl[i].wr) check($sformatf("tbl%0d_rdata", i), {8'd0, rd}, {8'd0, tbl[i].exp_rd});
            if (tbl[i].wr) model_write(tbl[i].a, tbl[i].d, tbl[i].be);
        end

        run_model("toggle_wr", 1'b1, 24'd20, 24'h5A5A5A, 3'b111, 1'b1);
        run_model("toggle_rd", 1'b0, 24'd20, 24'h0,      3'b000, 1'b1);

        old9 = ref_mem[9];
        @(negedge clk);
        req = 1'b1; wr = 1'b1; addr = 24'd9; wdata = ~old9; be = 3'b111;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_outputs", {8'd0, rdata, ready, err, busy, 5'd0}, 32'd0);
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        run_model("abort_read9", 1'b0, 24'd9, 24'h0, 3'b000, 1'b0);
        check("abort_old9", {8'd0, ref_mem[9]}, {8'd0, old9});

        for (int i = 0; i < 150; i++)
            run_model("rand", 1'($urandom), ($urandom_range(0, 9) == 0) ? 24'($urandom) : 24'($urandom_range(0, 270)),
                      24'($urandom), 3'($urandom), 1'($urandom));

        for (int k = 0; k < 4; k++) d0[k] = 24'($urandom);
        @(negedge clk);
        req0 = 1'b1; wr0 = 1'b1; addr0 = 24'd40; wdata0 = d0[0]; be0 = 3'b111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("ws0_ready%0d", k), {30'd0, ready0, busy0}, 32'd3);
            if (k >= 4) check($sformatf("ws0_rdata%0d", k), {8'd0, rdata0}, {8'd0, d0[k-4]});
            if (k == 7) req0 = 1'b0;
            else begin
                wr0 = (k + 1) < 4;
                addr0 = 24'(40 + ((k + 1) % 4));
                wdata0 = d0[(k + 1) % 4];
            end
            @(negedge clk);
            check($sformatf("ws0_gap%0d", k), {30'd0, ready0, busy0}, 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
